delay_timer: RTL and testbench
==============================

# delay_timer

Multi-channel programmable one-shot delay timer, the parametrised successor to the fixed single-channel delay used on the NeXT ASIC side. Each channel detects a rising edge on its trigger input, waits a runtime-programmable number of clock cycles, then emits a programmable-width output pulse. The block sits between synchronised bus/control strobes and the downstream sequencing logic that needs delayed, width-controlled enables.

## Interface
Parameters:
- `CH`, 4, number of independent channels
- `W`, 8, width of each per-channel delay field (delay range 0..2^W-1)
- `PW`, 4, width of each per-channel pulse-width field
- `RETRIG`, 0, 1 = a trigger edge during the delay phase restarts the delay; 0 = ignored

Ports (one clock domain; reset asynchronous, active-low):
- `clk` in 1: sole clock, all state on rising edge
- `reset_n` in 1: asynchronous active-low reset
- `trig` in CH: per-channel trigger level; rising edge starts a channel
- `delay` in CH*W: channel i delay at `[i*W +: W]`, sampled on accepted edge
- `width` in CH*PW: channel i pulse width at `[i*PW +: PW]`, sampled on accepted edge
- `pulse` out CH: registered delayed pulse per channel
- `busy` out CH: channel i in COUNT or PULSE
- `done` out CH: one-cycle strobe on the cycle after channel i's pulse falls

## Operation
- Per channel: edge detector (`trig_q` register, `edge = trig & ~trig_q`), W-bit delay counter, PW-bit width counter, 2-bit state.
- States: IDLE, COUNT, PULSE.
  - IDLE: on `edge`, load counter ← `delay`, width counter ← max(`width`,1), → COUNT.
  - COUNT: counter == 0 → PULSE; else counter − 1. If `RETRIG`=1 and `edge`: reload counter ← `delay`, width counter ← max(`width`,1), stay COUNT (reload wins over ==0 exit in the same cycle).
  - PULSE: width counter − 1; when width counter == 1 → IDLE.
- Edges arriving in PULSE, or in COUNT with `RETRIG`=0, are dropped (not queued).
- Edge on the last PULSE cycle is dropped; next accepted edge needs `trig` low then high again after return to IDLE.
- `width`=0 treated as 1. Delay/width inputs changing while busy have no effect.
- Channels fully independent; simultaneous edges on all channels all accepted.
- No arithmetic wraps: counters only decrement from loaded values and never pass 0.

## Timing
- Reset: `pulse`, `busy`, `done` = 0; all states IDLE; counters 0; `trig_q` = 0, so `trig` held high at reset release counts as an edge on the first clock.
- Reset asserted mid-operation: all channels abort immediately (asynchronous), outputs drop to 0 without `done`.
- Let edge t be the clock edge where `trig`=1 and `trig_q`=0 are sampled.
- `busy` high after edge t.
- `pulse` rises after edge t+D+1 (D = loaded delay), high for exactly P = max(width,1) cycles, falls after edge t+D+1+P.
- `busy` falls with `pulse`; `done` high for one cycle after that same edge.
- Minimum latency edge→pulse = 1 cycle (D=0); maximum 2^W cycles.
- Minimum retrigger interval (RETRIG=0): D+P+2 cycles between trigger rising edges.

## Configuration
- `DELAY_TIMER_SYNC_EN` defined: each `trig` bit passes through a two-flop synchroniser (both flops reset to 0) ahead of the edge detector; all edge-relative timing shifts by +2 cycles measured from `trig` input; `trig` may be asynchronous.
- Not defined: `trig` used directly; must be synchronous to `clk`; timing as stated above.

## Test plan
- Reset values: hold `reset_n`=0, toggle `trig` → `pulse`/`busy`/`done` stay 0; release with `trig`=0 → all remain 0.
- Basic: CH0 `delay`=5, `width`=3, 1-cycle `trig[0]` at edge t → `pulse[0]` high after edges t+6..t+8, `done[0]` one cycle after t+9, other channels idle.
- Boundaries: `delay`=0,`width`=0 → pulse 1 cycle after t+1; `delay`=255,`width`=15 → pulse after t+256 for 15 cycles.
- Retrigger: `delay`=10, second edge at t+4; RETRIG=0 → pulse at t+11; RETRIG=1 → pulse at t+15.
- Concurrency and abort: all 4 channels triggered same edge with delays 1,2,3,4 → staggered pulses; drop `reset_n` during CH3 PULSE → all outputs 0 immediately, no `done`.
- With `DELAY_TIMER_SYNC_EN`: repeat basic case → pulse shifted by exactly +2 cycles.

Source files
------------

// File: rtl/delay_timer.sv
// -----------------------------------------------------------------------------
// delay_timer
//
// Multi-channel programmable one-shot delay timer. Each channel watches its
// trigger for a rising edge, waits a programmable number of clock cycles, then
// drives a programmable-width pulse. A one-cycle done strobe follows the pulse.
//
// Parameters:
//   CH     - number of independent channels
//   W      - width of each per-channel delay field (delay 0..2^W-1)
//   PW     - width of each per-channel pulse-width field (0 is treated as 1)
//   RETRIG - 1: an edge while counting reloads the delay; 0: it is dropped
//
// Ports:
//   clk       in  1       sole clock, all state on rising edge
//   reset_n   in  1       asynchronous active-low reset
//   trig      in  CH      per-channel trigger level
//   delay     in  CH*W    channel i delay at [i*W +: W], sampled on edge
//   width     in  CH*PW   channel i pulse width at [i*PW +: PW], sampled on edge
//   pulse     out CH      registered delayed pulse
//   busy      out CH      channel in COUNT or PULSE
//   done      out CH      one-cycle strobe after the pulse falls
//   state_dbg out 2*CH    channel i FSM state at [2*i +: 2] (0 IDLE, 1 COUNT,
//                         2 PULSE)
//
// Build option:
//   DELAY_TIMER_SYNC_EN - when defined, each trig bit passes through a
//   two-flop synchroniser before edge detection (adds 2 cycles of latency
//   measured from the trig input; trig may then be asynchronous).
//
// Handshake: there is no valid/ready pair here; a trigger edge is accepted
// only in IDLE (or in COUNT when RETRIG=1) and is otherwise dropped, never
// queued.
// -----------------------------------------------------------------------------
module delay_timer #(
   parameter int CH     = 4,
   parameter int W      = 8,
   parameter int PW     = 4,
   parameter int RETRIG = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [CH-1:0]    trig,
   input  logic [CH*W-1:0]  delay,
   input  logic [CH*PW-1:0] width,
   output logic [CH-1:0]    pulse,
   output logic [CH-1:0]    busy,
   output logic [CH-1:0]    done,
   output logic [2*CH-1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      PULSE = 2'd2
   } state_t;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic          trig_s;
      logic          trig_q;
      logic          trig_edge;
      state_t        state;
      logic [W-1:0]  cnt;
      logic [PW-1:0] wcnt;
      logic [PW-1:0] width_ld;
      logic          pulse_r;
      logic          busy_r;
      logic          done_r;

`ifdef DELAY_TIMER_SYNC_EN
      logic [1:0] sync_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync_q <= 2'b00;
         end else begin
            sync_q <= {sync_q[0], trig[i]};
         end
      end

      assign trig_s = sync_q[1];
`else
      assign trig_s = trig[i];
`endif

      // trig_q resets to 0, so a trigger already high at reset release is
      // seen as an edge on the first clock.
      assign trig_edge = trig_s & ~trig_q;

      // A zero width still produces a one-cycle pulse.
      assign width_ld  = (width[i*PW +: PW] == '0) ? PW'(1) : width[i*PW +: PW];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            trig_q  <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            wcnt    <= '0;
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
         end else begin
            trig_q <= trig_s;
            done_r <= 1'b0;
            case (state)
               IDLE: begin
                  if (trig_edge) begin
                     cnt    <= delay[i*W +: W];
                     wcnt   <= width_ld;
                     state  <= COUNT;
                     busy_r <= 1'b1;
                  end
               end
               COUNT: begin
                  // A retrigger reload takes priority over the zero exit.
                  if ((RETRIG != 0) && trig_edge) begin
                     cnt  <= delay[i*W +: W];
                     wcnt <= width_ld;
                  end else if (cnt == '0) begin
                     state   <= PULSE;
                     pulse_r <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               PULSE: begin
                  wcnt <= wcnt - 1'b1;
                  if (wcnt == PW'(1)) begin
                     state   <= IDLE;
                     pulse_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end
               default: begin
                  state   <= IDLE;
                  pulse_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end

      assign pulse[i]            = pulse_r;
      assign busy[i]             = busy_r;
      assign done[i]             = done_r;
      assign state_dbg[2*i +: 2] = state;
   end

endmodule

// File: tb/tb_delay_timer.sv
// -----------------------------------------------------------------------------
// tb_delay_timer
//
// Drives two delay_timer instances from the same stimulus: dut0 with RETRIG=0
// and dut1 with RETRIG=1. Expected output words {pulse, busy, done} for both
// instances are built per scenario from the timing rules, queued as each
// stimulus cycle is driven, and compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_delay_timer;

   localparam int CH  = 4;
   localparam int W   = 8;
   localparam int PW  = 4;
   localparam int OW  = 3 * CH;
   localparam int NC  = 300;
`ifdef DELAY_TIMER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [CH-1:0]    trig = '0;
   logic [CH*W-1:0]  delay_bus = '0;
   logic [CH*PW-1:0] width_bus = '0;

   logic [CH-1:0]   pulse0, busy0, done0, pulse1, busy1, done1;
   logic [2*CH-1:0] st0, st1;

   delay_timer #(.CH(CH), .W(W), .PW(PW), .RETRIG(0)) dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .trig      (trig),
      .delay     (delay_bus),
      .width     (width_bus),
      .pulse     (pulse0),
      .busy      (busy0),
      .done      (done0),
      .state_dbg (st0)
   );

   delay_timer #(.CH(CH), .W(W), .PW(PW), .RETRIG(1)) dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .trig      (trig),
      .delay     (delay_bus),
      .width     (width_bus),
      .pulse     (pulse1),
      .busy      (busy1),
      .done      (done1),
      .state_dbg (st1)
   );

   // ---------------- scoreboard ----------------
   logic [2*OW-1:0] exp_q[$];
   logic [2*OW-1:0] exp_tr [0:NC-1];
   logic [CH-1:0]   trig_tr [0:NC-1];
   int total = 0;
   int bad   = 0;

   typedef struct {
      int ch;
      int d;
      int w;
      int p;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input int k);
      logic [2*OW-1:0] got;
      logic [2*OW-1:0] want;
      got = {pulse1, busy1, done1, pulse0, busy0, done0};
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s cyc=%0d scoreboard queue empty", name, k);
      end else begin
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, k, got, want);
         end
      end
   endtask

   task automatic clear_scn();
      for (int k = 0; k < NC; k++) begin
         exp_tr[k]  = '0;
         trig_tr[k] = '0;
      end
   endtask

   // Expected trace for one accepted edge sampled at scenario cycle k:
   // busy after edges k..k+d+p, pulse after k+d+1..k+d+p, done after k+d+p+1.
   task automatic add_trace(input int k, input int ch, input int d, input int p,
                            input logic [1:0] dm);
      int idx;
      for (int j = 0; j <= d + p + 1; j++) begin
         idx = k + LAT + j;
         if (idx < NC) begin
            for (int u = 0; u < 2; u++) begin
               if (dm[u]) begin
                  if (j <= d + p)            exp_tr[idx][u*OW + CH + ch]   = 1'b1;
                  if (j >= d + 1 && j <= d + p) exp_tr[idx][u*OW + 2*CH + ch] = 1'b1;
                  if (j == d + p + 1)        exp_tr[idx][u*OW + ch]        = 1'b1;
               end
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_ch(input int ch, input int d, input int w);
      logic [W-1:0]  dv;
      logic [PW-1:0] wv;
      dv = W'(d);
      wv = PW'(w);
      delay_bus[ch*W +: W]   = dv;
      width_bus[ch*PW +: PW] = wv;
   endtask

   task automatic run_scn(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         trig = trig_tr[k];
         exp_q.push_back(exp_tr[k]);
         @(posedge clk);
         #1;
         check(name, k);
      end
      trig = '0;
   endtask

   // ---------------- test ----------------
   initial begin
      vecs[0] = '{ch: 0, d: 5,   w: 3,  p: 3};
      vecs[1] = '{ch: 0, d: 0,   w: 0,  p: 1};
      vecs[2] = '{ch: 1, d: 255, w: 15, p: 15};
      vecs[3] = '{ch: 2, d: 7,   w: 1,  p: 1};
      vecs[4] = '{ch: 3, d: 2,   w: 9,  p: 9};
      vecs[5] = '{ch: 1, d: 1,   w: 0,  p: 1};

      // Reset held: toggling trig must not move any output.
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         trig = (k % 2 == 0) ? 4'hF : 4'h0;
         exp_q.push_back('0);
         @(posedge clk);
         #1;
         check("reset_hold", k);
      end
      total++;
      if ({st1, st0} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h want=0", {st1, st0});
      end

      // Release with trig low: nothing starts.
      trig    = '0;
      reset_n = 1'b1;
      clear_scn();
      run_scn("reset_release", 5);

      // Table-driven single-channel vectors.
      foreach (vecs[v]) begin
         clear_scn();
         delay_bus = '0;
         width_bus = '0;
         set_ch(vecs[v].ch, vecs[v].d, vecs[v].w);
         trig_tr[1][vecs[v].ch] = 1'b1;
         add_trace(1, vecs[v].ch, vecs[v].d, vecs[v].p, 2'b11);
         run_scn($sformatf("vec%0d", v), vecs[v].d + vecs[v].p + LAT + 5);
      end

      // Retrigger at t+4 with delay 10: dut0 pulses at t+11, dut1 at t+15.
      clear_scn();
      set_ch(0, 10, 2);
      trig_tr[1][0] = 1'b1;
      trig_tr[5][0] = 1'b1;
      add_trace(1, 0, 10, 2, 2'b01);
      add_trace(5, 0, 10, 2, 2'b10);
      for (int k = 1; k < 5; k++) exp_tr[k + LAT][OW + CH] = 1'b1;
      run_scn("retrig_mid", 5 + 10 + 2 + LAT + 4);

      // Retrigger on the cycle the counter would exit: reload wins in dut1.
      clear_scn();
      set_ch(0, 3, 1);
      trig_tr[1][0] = 1'b1;
      trig_tr[5][0] = 1'b1;
      add_trace(1, 0, 3, 1, 2'b01);
      add_trace(5, 0, 3, 1, 2'b10);
      for (int k = 1; k < 5; k++) exp_tr[k + LAT][OW + CH] = 1'b1;
      run_scn("retrig_zero", 5 + 3 + 1 + LAT + 4);

      // Edges during PULSE and on the last PULSE cycle are dropped; a fresh
      // low-then-high after returning to IDLE is accepted.
      clear_scn();
      set_ch(2, 2, 4);
      trig_tr[1][2]  = 1'b1;
      trig_tr[5][2]  = 1'b1;
      trig_tr[8][2]  = 1'b1;
      trig_tr[10][2] = 1'b1;
      add_trace(1, 2, 2, 4, 2'b11);
      add_trace(10, 2, 2, 4, 2'b11);
      run_scn("drop_pulse", 10 + 2 + 4 + LAT + 4);

      // All channels on one edge with delays 1..4, then abort in CH3 PULSE.
      clear_scn();
      for (int c = 0; c < CH; c++) begin
         set_ch(c, c + 1, 2);
         add_trace(1, c, c + 1, 2, 2'b11);
      end
      trig_tr[1] = 4'hF;
      run_scn("concurrent", 7 + LAT);
      reset_n = 1'b0;
      #1;
      exp_q.push_back('0);
      check("abort_now", 0);
      for (int k = 1; k < 4; k++) begin
         exp_q.push_back('0);
         @(posedge clk);
         #1;
         check("abort_hold", k);
      end

      // trig already high at reset release counts as an edge on the first clock.
      clear_scn();
      delay_bus = '0;
      width_bus = '0;
      set_ch(2, 3, 1);
      for (int k = 0; k < 12; k++) trig_tr[k] = 4'h4;
      add_trace(0, 2, 3, 1, 2'b11);
      reset_n = 1'b1;
      run_scn("trig_high_release", 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
